// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding and
// default parameter values used by fetch_unit.
// No ports; imported with "import fetch_unit_pkg::*".
package fetch_unit_pkg;

   // One instruction in flight at a time; the FSM walks these states in order.
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_IMEM_REQ = 3'd1,
      S_ISSUE    = 3'd2,
      S_RELEASE  = 3'd3,
      S_NEXT_PC  = 3'd4
   } fetch_state_t;

   localparam int          DEF_DATA_WIDTH = 32;
   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
   localparam int          DEF_PC_INCR    = 4;
   localparam int          DEF_CNT_WIDTH  = 32;

endpackage

// File: rtl/fetch_unit.sv
// Purpose : instruction fetch stage; holds PC, reads one word, hands it to decode.
// Latency : IMEM_REQ -> ISSUE -> RELEASE -> NEXT_PC loop, one instruction at a time.
// Backpr. : holds in IMEM_REQ until imem_valid, in ISSUE until compute_valid,
//           in RELEASE until compute_valid drops.
// Ports   : clk/rst (async active-low), run; imem_req/imem_addr/imem_valid/imem_rdata
//           to instruction memory; inst/compute_req/compute_valid/branch_flag/new_pc
//           to decode; pc and retired_count status.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEF_RESET_PC),
   parameter int                    PC_INCR    = DEF_PC_INCR,
   parameter int                    CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_valid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] inst,
   output logic                  compute_req,
   input  logic                  compute_valid,
   input  logic                  branch_flag,
   input  logic [DATA_WIDTH-1:0] new_pc,
   output logic [DATA_WIDTH-1:0] pc,
   output logic [CNT_WIDTH-1:0]  retired_count
);

   // Branch targets are word aligned by clearing the two low bits.
   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

   fetch_state_t          r_state;
   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] r_inst;
   logic [DATA_WIDTH-1:0] r_tgt;
   logic                  r_take;
   logic [CNT_WIDTH-1:0]  r_retired;

   logic [DATA_WIDTH-1:0] w_pc_seq;
   logic [DATA_WIDTH-1:0] w_pc_next;

   // Sequential increment wraps modulo 2^DATA_WIDTH.
   assign w_pc_seq  = r_pc + DATA_WIDTH'(PC_INCR);
   assign w_pc_next = r_take ? (r_tgt & ALIGN_MASK) : w_pc_seq;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_pc      <= RESET_PC;
         r_inst    <= '0;
         r_tgt     <= '0;
         r_take    <= 1'b0;
         r_retired <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (run) r_state <= S_IMEM_REQ;
            end
            S_IMEM_REQ: begin
               // inst only ever changes on this capture edge; decode is
               // combinational on it through the rest of the instruction.
               if (imem_valid) begin
                  r_inst  <= imem_rdata;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (compute_valid) begin
                  r_take  <= branch_flag;
                  r_tgt   <= new_pc;
                  r_state <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               // Decode must return to its wait state before the next issue,
               // otherwise a stale compute_valid would retire the next word.
               if (!compute_valid) r_state <= S_NEXT_PC;
            end
            S_NEXT_PC: begin
               r_pc      <= w_pc_next;
               r_retired <= r_retired + CNT_WIDTH'(1);
               r_state   <= run ? S_IMEM_REQ : S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Moore decode from the state register: no input-to-output path, and the
   // strobes fall together with the asynchronous reset of r_state.
   assign imem_req      = (r_state == S_IMEM_REQ);
   assign compute_req   = (r_state == S_ISSUE);
   assign imem_addr     = r_pc;
   assign pc            = r_pc;
   assign inst          = r_inst;
   assign retired_count = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic        compute_req;
   logic        compute_valid;
   logic        branch_flag;
   logic [31:0] new_pc;
   logic [31:0] pc;
   logic [31:0] retired_count;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: architectural PC, retire count, last fetched word.
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   logic [31:0] m_inst;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .run           (run),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_valid    (imem_valid),
      .imem_rdata    (imem_rdata),
      .inst          (inst),
      .compute_req   (compute_req),
      .compute_valid (compute_valid),
      .branch_flag   (branch_flag),
      .new_pc        (new_pc),
      .pc            (pc),
      .retired_count (retired_count)
   );

   // Instruction memory contents as a pure function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      int k = 0;
      while (imem_req !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      chk("imem_req_rise", 32'(imem_req), 32'd1);
   endtask

   // One full instruction: memory waits mw cycles, decode waits dw cycles,
   // compute_valid lingers hw cycles after compute_req falls.
   task automatic do_instr(input int mw, input int dw, input int hw, input bit br,
                           input logic [31:0] tgt, input bit run_next);
      logic [31:0] word;
      wait_req();
      chk("imem_addr", imem_addr, m_pc);
      chk("pc_at_req", pc, m_pc);
      chk("cnt_at_req", retired_count, m_cnt);
      chk("creq_at_req", 32'(compute_req), 32'd0);
      word = mem_word(m_pc);
      for (int i = 0; i < mw; i++) begin
         imem_valid = 1'b0;
         imem_rdata = $urandom;
         step();
         chk("stall_ireq", 32'(imem_req), 32'd1);
         chk("stall_addr", imem_addr, m_pc);
         chk("stall_creq", 32'(compute_req), 32'd0);
      end
      imem_valid = 1'b1;
      imem_rdata = word;
      step();
      m_inst     = word;
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      run        = run_next;
      chk("issue_creq", 32'(compute_req), 32'd1);
      chk("issue_ireq", 32'(imem_req), 32'd0);
      chk("inst", inst, m_inst);
      for (int i = 0; i < dw; i++) begin
         compute_valid = 1'b0;
         branch_flag   = 1'($urandom);
         new_pc        = $urandom;
         step();
         chk("issue_hold_creq", 32'(compute_req), 32'd1);
         chk("issue_hold_inst", inst, m_inst);
      end
      compute_valid = 1'b1;
      branch_flag   = br;
      new_pc        = tgt;
      step();
      branch_flag = ~br;
      new_pc      = $urandom;
      imem_valid  = 1'b0;
      chk("release_creq", 32'(compute_req), 32'd0);
      for (int i = 0; i < hw; i++) begin
         compute_valid = 1'b1;
         step();
         chk("release_hold_creq", 32'(compute_req), 32'd0);
         chk("release_hold_cnt", retired_count, m_cnt);
         chk("release_hold_pc", pc, m_pc);
      end
      compute_valid = 1'b0;
      step();
      chk("nextpc_cnt", retired_count, m_cnt);
      chk("nextpc_ireq", 32'(imem_req), 32'd0);
      m_pc  = br ? (tgt & 32'hFFFF_FFFC) : m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
      step();
      chk("pc_update", pc, m_pc);
      chk("retired", retired_count, m_cnt);
      chk("inst_held", inst, m_inst);
      chk("run_follow", 32'(imem_req), 32'(run_next));
   endtask

   initial begin
      rst           = 1'b0;
      run           = 1'b0;
      imem_valid    = 1'b0;
      imem_rdata    = '0;
      compute_valid = 1'b0;
      branch_flag   = 1'b0;
      new_pc        = '0;
      m_pc          = 32'h0;
      m_cnt         = 32'h0;
      m_inst        = 32'h0;

      // Reset values before any clock edge.
      #1;
      chk("rst_ireq", 32'(imem_req), 32'd0);
      chk("rst_creq", 32'(compute_req), 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_cnt", retired_count, 32'h0);
      chk("rst_inst", inst, 32'h0);
      step();
      step();
      rst = 1'b1;
      step();
      chk("idle_no_run", 32'(imem_req), 32'd0);
      run = 1'b1;

      // Sequential fetch at 0, then a taken branch to a misaligned target.
      do_instr(0, 0, 0, 1'b0, 32'h0, 1'b1);
      chk("seq_addr_4", imem_addr, 32'h4);
      do_instr(0, 0, 0, 1'b1, 32'h0000_0102, 1'b1);
      chk("branch_addr_100", imem_addr, 32'h100);
      // Memory stall, then lingering compute_valid.
      do_instr(3, 1, 0, 1'b0, 32'h0, 1'b1);
      do_instr(0, 0, 2, 1'b0, 32'h0, 1'b1);

      // Reset asserted in the middle of S_ISSUE.
      wait_req();
      imem_valid = 1'b1;
      imem_rdata = mem_word(m_pc);
      step();
      imem_valid = 1'b0;
      chk("pre_rst_creq", 32'(compute_req), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_ireq", 32'(imem_req), 32'd0);
      chk("midrst_creq", 32'(compute_req), 32'd0);
      chk("midrst_pc", pc, 32'h0);
      chk("midrst_cnt", retired_count, 32'h0);
      // imem_valid at a clock edge during reset is ignored.
      imem_valid = 1'b1;
      step();
      chk("rst_wins_ireq", 32'(imem_req), 32'd0);
      chk("rst_wins_creq", 32'(compute_req), 32'd0);
      chk("rst_wins_inst", inst, 32'h0);
      imem_valid = 1'b0;
      rst   = 1'b1;
      m_pc  = 32'h0;
      m_cnt = 32'h0;

      // PC wrap, then run dropped during S_ISSUE.
      do_instr(0, 0, 0, 1'b1, 32'hFFFF_FFFE, 1'b1);
      chk("wrap_base", pc, 32'hFFFF_FFFC);
      do_instr(1, 0, 0, 1'b0, 32'h0, 1'b0);
      chk("wrap_zero", pc, 32'h0);
      for (int i = 0; i < 3; i++) begin
         imem_valid    = 1'($urandom);
         compute_valid = 1'($urandom);
         step();
         chk("parked_ireq", 32'(imem_req), 32'd0);
         chk("parked_creq", 32'(compute_req), 32'd0);
         chk("parked_pc", pc, m_pc);
         chk("parked_cnt", retired_count, m_cnt);
      end
      imem_valid    = 1'b0;
      compute_valid = 1'b0;

      // Randomized traffic against the model.
      for (int i = 0; i < 40; i++) begin
         run = 1'b1;
         do_instr($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                  ($urandom_range(0, 3) == 0), $urandom, (i % 13) != 12);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
